// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Arbitrates the register file's single synchronous write port
//                between the MEM/load writeback (req0, older) and the EXE/ALU
//                writeback (req1, younger). Valid/ready handshake, registered
//                write port, saturating contention counter for debug.
//                Optional macro REGFILE_WB_BYPASS_EN adds a combinational
//                write-to-read forwarding path for two read ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DW        = 32,
  parameter int AW        = 5,
  parameter int PRIO_MODE = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  // MEM/load writeback requester
  input  logic             req0_valid,
  input  logic [AW-1:0]    req0_addr,
  input  logic [DW-1:0]    req0_data,
  output logic             req0_ready,
  // EXE/ALU writeback requester
  input  logic             req1_valid,
  input  logic [AW-1:0]    req1_addr,
  input  logic [DW-1:0]    req1_data,
  output logic             req1_ready,
  // Register file write port
  output logic             wen,
  output logic [AW-1:0]    waddr,
  output logic [DW-1:0]    wdata,
`ifdef REGFILE_WB_BYPASS_EN
  // Read-port forwarding
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  input  logic [DW-1:0]    rf_rdata1,
  input  logic [DW-1:0]    rf_rdata2,
  output logic [DW-1:0]    rdata1,
  output logic [DW-1:0]    rdata2,
`endif
  // Debug
  output logic [CNT_W-1:0] conflict_cnt
);

  // Fixed-priority mode lets req0 win every contended cycle.
  localparam bit c_FIXED_PRIO = (PRIO_MODE == 1);

  // Round-robin preference: which requester wins the next contended cycle.
  typedef enum logic {
    PREF0 = 1'b0,
    PREF1 = 1'b1
  } rr_e;

  rr_e              rr_q,    rr_d;
  logic             wen_q,   wen_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic             w_both_valid;
  logic             w_same_addr;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_xfer;
  logic [AW-1:0]    w_win_addr;
  logic [DW-1:0]    w_win_data;

  // Grant selection; depends only on valid, addresses and the pointer.
  always_comb begin
    w_both_valid = req0_valid && req1_valid;
    w_same_addr  = (req0_addr == req1_addr);
    // req0 wins when alone, on a same-address collision (keeps WAW order),
    // in fixed-priority mode, or when the pointer prefers it.
    w_grant0     = req0_valid && (!req1_valid || w_same_addr ||
                                  c_FIXED_PRIO || (rr_q == PREF0));
    w_grant1     = req1_valid && !w_grant0;
    // A pending request at a reset edge is dropped, never accepted.
    req0_ready   = w_grant0 && !reset;
    req1_ready   = w_grant1 && !reset;
    w_xfer       = req0_ready || req1_ready;
    w_win_addr   = req0_ready ? req0_addr : req1_addr;
    w_win_data   = req0_ready ? req0_data : req1_data;
  end

  // Next-state for the write port, pointer and contention counter.
  always_comb begin
    rr_d    = rr_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    if (w_xfer) begin
      // Prefer whichever requester did not just win.
      rr_d = req0_ready ? PREF1 : PREF0;
      if (w_win_addr != '0) begin
        wen_d   = 1'b1;
        waddr_d = w_win_addr;
        wdata_d = w_win_data;
      end else begin
        // r0 is hardwired to zero: the request is consumed but not written.
        waddr_d = '0;
        wdata_d = '0;
      end
    end
    if (w_both_valid && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q    <= PREF0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      rr_q    <= rr_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wen          = wen_q;
  assign waddr        = waddr_q;
  assign wdata        = wdata_q;
  assign conflict_cnt = cnt_q;

`ifdef REGFILE_WB_BYPASS_EN
  // Forward the write being committed this cycle to a matching read port.
  always_comb begin
    rdata1 = (wen_q && (waddr_q != '0) && (waddr_q == raddr1)) ? wdata_q : rf_rdata1;
    rdata2 = (wen_q && (waddr_q != '0) && (waddr_q == raddr2)) ? wdata_q : rf_rdata2;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Directed self-checking bench for regfile_wb_arbiter.
//                Instance A: round-robin, 16-bit counter.
//                Instance B: fixed priority, 3-bit counter (saturation).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        v0, v1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;

  logic        rdy0_a, rdy1_a, wen_a;
  logic [4:0]  waddr_a;
  logic [31:0] wdata_a;
  logic [15:0] cnt_a;

  logic        rdy0_b, rdy1_b, wen_b;
  logic [4:0]  waddr_b;
  logic [31:0] wdata_b;
  logic [2:0]  cnt_b;

`ifdef REGFILE_WB_BYPASS_EN
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rf_rdata1, rf_rdata2, rdata1_a, rdata2_a, rdata1_b, rdata2_b;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DW(32), .AW(5), .PRIO_MODE(0), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(rdy0_a),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(rdy1_a),
    .wen(wen_a), .waddr(waddr_a), .wdata(wdata_a),
`ifdef REGFILE_WB_BYPASS_EN
    .raddr1(raddr1), .raddr2(raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rdata1(rdata1_a), .rdata2(rdata2_a),
`endif
    .conflict_cnt(cnt_a)
  );

  regfile_wb_arbiter #(.DW(32), .AW(5), .PRIO_MODE(1), .CNT_W(3)) u_dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(rdy0_b),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(rdy1_b),
    .wen(wen_b), .waddr(waddr_b), .wdata(wdata_b),
`ifdef REGFILE_WB_BYPASS_EN
    .raddr1(raddr1), .raddr2(raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rdata1(rdata1_b), .rdata2(rdata2_b),
`endif
    .conflict_cnt(cnt_b)
  );

  // Count one comparison and report it if the observed value is wrong.
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs mid-cycle, then let combinational readies settle.
  task automatic drive(input logic r, input logic iv0, input logic [4:0] ia0, input logic [31:0] id0,
                       input logic iv1, input logic [4:0] ia1, input logic [31:0] id1);
    @(negedge clk);
    reset = r;
    v0 = iv0; a0 = ia0; d0 = id0;
    v1 = iv1; a1 = ia1; d1 = id1;
    #1;
  endtask

  // Advance through the next rising edge and sample registered outputs after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check instance A's readies and the write port it produces on the next edge.
  task automatic step_a(input string tag, input logic er0, input logic er1, input logic ewen,
                        input logic [4:0] ewaddr, input logic [31:0] ewdata, input logic [15:0] ecnt);
    check_eq({tag, ".rdy0"}, 64'(rdy0_a), 64'(er0));
    check_eq({tag, ".rdy1"}, 64'(rdy1_a), 64'(er1));
    tick();
    check_eq({tag, ".wen"},   64'(wen_a),   64'(ewen));
    check_eq({tag, ".waddr"}, 64'(waddr_a), 64'(ewaddr));
    check_eq({tag, ".wdata"}, 64'(wdata_a), 64'(ewdata));
    check_eq({tag, ".cnt"},   64'(cnt_a),   64'(ecnt));
  endtask

  initial begin
    reset = 1'b1;
    v0 = 1'b0; a0 = '0; d0 = '0;
    v1 = 1'b0; a1 = '0; d1 = '0;
`ifdef REGFILE_WB_BYPASS_EN
    raddr1 = '0; raddr2 = '0; rf_rdata1 = '0; rf_rdata2 = 32'h5555_AAAA;
`endif

    // Reset held two cycles with both requesters valid: nothing accepted.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 5'd3, 32'hD0, 1'b1, 5'd7, 32'hD1);
      step_a("rst_hold", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 16'd0);
      check_eq("rst_hold.b_rdy0", 64'(rdy0_b), 64'd0);
    end

    // Single req0 to r5.
    drive(1'b0, 1'b1, 5'd5, 32'hA5A5_0001, 1'b0, 5'd0, 32'h0);
    step_a("single0", 1'b1, 1'b0, 1'b1, 5'd5, 32'hA5A5_0001, 16'd0);
`ifdef REGFILE_WB_BYPASS_EN
    raddr1 = 5'd5; rf_rdata1 = 32'h0; raddr2 = 5'd6;
    #1;
    check_eq("byp.fwd1",   64'(rdata1_a), 64'hA5A5_0001);
    check_eq("byp.nofwd2", 64'(rdata2_a), 64'h5555_AAAA);
`endif

    // Idle: wen drops, address/data hold.
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step_a("idle", 1'b0, 1'b0, 1'b0, 5'd5, 32'hA5A5_0001, 16'd0);

    // Mid-stream reset with both pending: dropped, outputs cleared, pointer back to req0.
    drive(1'b1, 1'b1, 5'd3, 32'hD0, 1'b1, 5'd7, 32'hD1);
    step_a("rst_mid", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 16'd0);

    // Contention 3 vs 7: round-robin alternates 0,1,0; B always grants req0.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 5'd3, 32'hD0, 1'b1, 5'd7, 32'hD1);
      check_eq("rr.b_rdy0", 64'(rdy0_b), 64'd1);
      step_a("rr", (k % 2) == 0, (k % 2) == 1, 1'b1,
             ((k % 2) == 0) ? 5'd3 : 5'd7, ((k % 2) == 0) ? 32'hD0 : 32'hD1, 16'(k + 1));
      check_eq("rr.b_waddr", 64'(waddr_b), 64'd3);
    end

    // Pointer now prefers req1, but a same-address collision still favours req0.
    drive(1'b0, 1'b1, 5'd9, 32'd1, 1'b1, 5'd9, 32'd2);
    step_a("waw0", 1'b1, 1'b0, 1'b1, 5'd9, 32'd1, 16'd4);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'd2);
    step_a("waw1", 1'b0, 1'b1, 1'b1, 5'd9, 32'd2, 16'd4);

    // Writes to r0 are accepted but suppressed.
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step_a("r0_req1", 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 16'd4);
    drive(1'b0, 1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 32'h0);
    step_a("r0_req0", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 16'd4);

    // The r0 transfer by req0 advanced the pointer: contention starts with req1.
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 5'd2, 32'hC2, 1'b1, 5'd6, 32'hC6);
      check_eq("rr2.b_rdy1", 64'(rdy1_b), 64'd0);
      step_a("rr2", (k % 2) == 1, (k % 2) == 0, 1'b1,
             ((k % 2) == 0) ? 5'd6 : 5'd2, ((k % 2) == 0) ? 32'hC6 : 32'hC2, 16'(k + 5));
    end
    // Nine contended cycles since reset: the 3-bit counter saturates at 7.
    check_eq("sat.b_cnt", 64'(cnt_b), 64'd7);

    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    check_eq("end.wen", 64'(wen_a), 64'd0);
    check_eq("end.cnt", 64'(cnt_a), 64'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
